// File: rtl/nes_cpu_bus_ctrl.sv
// NES CPU-side bus controller: memory-map decode, open-bus latch and OAM DMA engine.
// Sits between the 6502 core and the RAM / PPU / IO / SRAM / PRG ROM targets.
module nes_cpu_bus_ctrl #(
  parameter int          PRG_ROM_KB    = 32,
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        ren,
  input  logic        wen,
  output logic [7:0]  cpu_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        ram_cs,
  output logic        ppu_cs,
  output logic        io_cs,
  output logic        sram_cs,
  output logic        rom_cs,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  ppu_rdata,
  input  logic [7:0]  io_rdata,
  input  logic [7:0]  sram_rdata,
  input  logic [7:0]  rom_rdata
);

  localparam int T_RAM  = 0;
  localparam int T_PPU  = 1;
  localparam int T_IO   = 2;
  localparam int T_SRAM = 3;
  localparam int T_ROM  = 4;

  typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_ALIGN, S_RD, S_WR} dma_state_e;

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        odd_q, odd_d;
  logic        parity_q;
  logic [4:0]  sel_q;
  logic        core_rd_q;
  logic [7:0]  bus_q;

  logic [15:0] acc_addr;
  logic        acc_rd, acc_wr, acc_live;
  logic [4:0]  sel;
  logic [14:0] addr_dec;
  logic [7:0]  sel_rdata;
  logic [7:0]  rdata_arr    [5];
  logic [7:0]  rdata_masked [5];

  assign rdata_arr[T_RAM]  = ram_rdata;
  assign rdata_arr[T_PPU]  = ppu_rdata;
  assign rdata_arr[T_IO]   = io_rdata;
  assign rdata_arr[T_SRAM] = sram_rdata;
  assign rdata_arr[T_ROM]  = rom_rdata;

  for (genvar gi = 0; gi < 5; gi++) begin : g_rmux
    assign rdata_masked[gi] = sel_q[gi] ? rdata_arr[gi] : 8'h00;
  end

  // A read that hit no target leaves the open-bus value on the data lines.
  assign sel_rdata = (sel_q == 5'b0) ? bus_q :
                     (rdata_masked[0] | rdata_masked[1] | rdata_masked[2] |
                      rdata_masked[3] | rdata_masked[4]);

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    odd_d     = odd_q;
    acc_addr  = cpu_addr_out;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    mem_wdata = cpu_data_out;
    case (state_q)
      S_IDLE: begin
        acc_wr = wen;
        acc_rd = ren & ~wen;
        if (wen && cpu_addr_out == DMA_REG_ADDR) begin
          state_d = S_DUMMY;
          page_d  = cpu_data_out;
          odd_d   = parity_q;
        end
      end
      // The parity captured on the triggering write decides the extra alignment cycle.
      S_DUMMY: state_d = odd_q ? S_ALIGN : S_RD;
      S_ALIGN: state_d = S_RD;
      S_RD: begin
        acc_addr = {page_q, idx_q};
        acc_rd   = 1'b1;
        state_d  = S_WR;
      end
      S_WR: begin
        acc_addr  = OAM_DATA_ADDR;
        acc_wr    = 1'b1;
        mem_wdata = sel_rdata;
        idx_d     = idx_q + 8'd1;
        state_d   = (idx_q == 8'hFF) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel      = 5'b0;
    addr_dec = 15'b0;
    if (acc_addr < 16'h2000) begin
      sel[T_RAM] = 1'b1;
      addr_dec   = {4'b0, acc_addr[10:0]};
    end else if (acc_addr < 16'h4000) begin
      sel[T_PPU] = 1'b1;
      addr_dec   = {12'b0, acc_addr[2:0]};
    end else if (acc_addr < 16'h4018) begin
      sel[T_IO] = !(acc_wr && acc_addr == DMA_REG_ADDR);
      addr_dec  = {10'b0, acc_addr[4:0]};
    end else if (acc_addr >= 16'h6000 && acc_addr < 16'h8000) begin
      sel[T_SRAM] = 1'b1;
      addr_dec    = {2'b0, acc_addr[12:0]};
    end else if (acc_addr >= 16'h8000) begin
      sel[T_ROM] = 1'b1;
      addr_dec   = (PRG_ROM_KB == 16) ? {1'b0, acc_addr[13:0]} : acc_addr[14:0];
    end
  end

  assign acc_live = (acc_rd | acc_wr) & ~b_rst & (sel != 5'b0);
  assign {rom_cs, sram_cs, io_cs, ppu_cs, ram_cs} = acc_live ? sel : 5'b0;
  assign mem_addr    = acc_live ? addr_dec : 15'b0;
  assign mem_re      = acc_live & acc_rd;
  assign mem_we      = acc_live & acc_wr & ~sel[T_ROM];
  assign rdy         = (state_q == S_IDLE);
  assign dma_active  = ~rdy;
  assign cpu_data_in = core_rd_q ? sel_rdata : bus_q;

  always_ff @(posedge clk) begin
    if (b_rst) begin
      state_q   <= S_IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      odd_q     <= 1'b0;
      parity_q  <= 1'b0;
      sel_q     <= 5'b0;
      core_rd_q <= 1'b0;
      bus_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      odd_q     <= odd_d;
      parity_q  <= ~parity_q;
      sel_q     <= acc_rd ? sel : 5'b0;
      core_rd_q <= (state_q == S_IDLE) & acc_rd;
      if (core_rd_q && sel_q != 5'b0) bus_q <= sel_rdata;
      if (state_q == S_IDLE && wen) bus_q <= cpu_data_out;
    end
  end

endmodule
